coin_credit_accumulator: RTL and testbench
==========================================

# coin_credit_accumulator

Credit front end for the vending machine. It sits between the button/switch debouncers and the main state machine, which reads the running credit from it. It turns debounced coin-insert presses and denomination switches into a saturating 4-bit credit value. It answers vend and refund requests from the state machine with one-cycle result pulses, and optionally refunds idle credit automatically after a timeout.

## Interface
- `MAX_CREDIT`, 15: largest credit held; must be ≤15.
- `TIMEOUT_CYCLES`, 50_000_000: idle cycles in CREDIT before auto-refund (1 s at 50 MHz); counter width is `$clog2(TIMEOUT_CYCLES)`.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `coin_btn` in 1: debounced coin-insert level, active-high.
- `coin_value` in 4: denomination from switches, sampled on the `coin_btn` rising edge.
- `vend_req` in 1: one-cycle request from the state machine.
- `price` in 4: item price, valid with `vend_req`.
- `refund_req` in 1: one-cycle refund request.
- `credit` out 4: current credit, registered.
- `vend_ok` out 1: one-cycle pulse; price deducted.
- `vend_deny` out 1: one-cycle pulse; insufficient credit.
- `coin_reject` out 1: one-cycle pulse; coin refused.
- `refund_valid` out 1: one-cycle pulse; refund issued.
- `refund_amount` out 4: amount of the last refund, held until the next refund or reset.
- `refund_auto` out 1: high with `refund_valid` when the refund came from the timeout.

## Operation
- **Coin edge detection.** `coin_btn` is registered once, and a rising edge is detected against the registered copy.
- **Pending slot.** On an edge, {`coin_value`} goes into a single pending slot.
  - If the slot is already full, the new coin raises `coin_reject` and is dropped.
  - If `coin_value` is 0, the edge is ignored with no pulse.
- **States:** IDLE (credit 0), CREDIT (credit > 0), REFUND (one cycle, drives the refund pulse, then returns to IDLE).
- **Per-cycle priority:** refund_req / timeout > vend_req > pending coin. A pending coin that loses arbitration stays pending and is applied the next cycle.
- **Apply coin:**
  - If `credit + value` ≤ MAX_CREDIT: credit += value and go to CREDIT.
  - Otherwise: `coin_reject`, credit unchanged.
  - Either way the slot is cleared.
  - Addition is done 5 bits wide, so there is no wrap-around.
- **Vend:**
  - If `price` ≤ credit: credit −= price and `vend_ok`. If the result is 0, go to IDLE.
  - Otherwise: `vend_deny`, credit unchanged.
  - A vend with price 0 gives `vend_ok` and leaves credit unchanged.
  - A vend in IDLE with price > 0 gives `vend_deny`.
- **Refund:**
  - In CREDIT: `refund_amount` ← credit, credit ← 0, go to REFUND.
  - In IDLE: ignored, no pulse.
  - In REFUND: ignored.
- **Timeout counter.**
  - Clears on entering CREDIT, on any accepted coin, and on any `vend_ok` or `vend_deny`.
  - Otherwise it counts each cycle while in CREDIT.
  - At TIMEOUT_CYCLES−1 it acts as a refund with `refund_auto` = 1.
- **Output exclusivity.** At most one of `vend_ok`, `vend_deny`, and refund is issued per cycle. `coin_reject` can coincide with any of them, because a second-edge reject is independent of arbitration.

## Timing
- **Reset values:** credit 0, all pulses 0, `refund_amount` 0, `refund_auto` 0, state IDLE, pending slot empty, edge register 0, timeout counter 0.
- **Reset mid-operation:** pending coin and credit are discarded, with no refund pulse.
- **Coin latency:**
  - Edge detected one cycle after `coin_btn` rises.
  - `credit` updates on the following edge, i.e. 2 cycles after `coin_btn` rises, when the slot is not blocked.
- **Request latency:** the response to `vend_req` / `refund_req` is registered, so the pulse and the `credit` change appear on the edge after the request cycle (1-cycle latency).
- **Refund timing:** `refund_valid` and `refund_amount` are valid in the same cycle. `credit` already reads 0 in that cycle.
- **Request rules:** requests are level-sampled every cycle. A requester holding `vend_req` high for N cycles gets N responses, so the state machine must pulse it.

## Configuration
- **`COIN_AUTO_REFUND_EN` defined:** the timeout counter and auto-refund path are compiled in, as described above.
- **`COIN_AUTO_REFUND_EN` undefined:**
  - No counter is built.
  - Credit is held indefinitely.
  - `refund_auto` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- **Coins then vend:** coin 5, coin 4 (`coin_btn` edges), then `vend_req` with price 7 → `credit` reads 5, then 9, then `vend_ok` with `credit` 2.
- **Deny, then exact vend:** credit 3, `vend_req` price 6 → `vend_deny`, `credit` stays 3. Then price 3 → `vend_ok`, `credit` 0, state IDLE.
- **Overflow:** credit 12 (MAX 15), coin 4 → `coin_reject`, `credit` stays 12. Then coin 3 → `credit` 15.
- **Simultaneous events:** coin 2 edge in the same cycle as `refund_req` with credit 6 → `refund_valid`, `refund_amount` 6, `credit` 0. The coin is applied next cycle, giving `credit` 2.
- **Auto-refund:** with the macro on and `TIMEOUT_CYCLES` = 20, credit 4 and no activity → `refund_valid` with `refund_auto` 1 and `refund_amount` 4 after 20 cycles. Macro off → `credit` still 4 after 100 cycles.
- **Reset mid-operation:** reset asserted with credit 9 and a coin pending → next cycle `credit` 0, no pulses, and the pending coin is never applied.

Source files
------------

// File: rtl/coin_credit_accumulator.sv
// coin_credit_accumulator
// Credit front end for the vending machine. Debounced coin presses build a
// saturating credit, and vend/refund requests get one-cycle result pulses.
// Optional idle-timeout auto-refund is compiled in when COIN_AUTO_REFUND_EN
// is defined. Without it, credit is held indefinitely and refund_auto stays 0.
module coin_credit_accumulator #(
  parameter int MAX_CREDIT     = 15,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_btn,
  input  logic [3:0] coin_value,
  input  logic       vend_req,
  input  logic [3:0] price,
  input  logic       refund_req,
  output logic [3:0] credit,
  output logic       vend_ok,
  output logic       vend_deny,
  output logic       coin_reject,
  output logic       refund_valid,
  output logic [3:0] refund_amount,
  output logic       refund_auto
);

  typedef enum logic [1:0] {ST_IDLE, ST_CREDIT, ST_REFUND} state_t;

  localparam logic [4:0] MAX_SUM = 5'(MAX_CREDIT);

  state_t     state, state_nx;
  logic       coin_q;
  logic       coin_edge;
  logic       pend_valid, pend_valid_nx;
  logic [3:0] pend_value, pend_value_nx;
  logic [4:0] coin_sum;
  logic [3:0] credit_nx;
  logic [3:0] refund_amount_nx;
  logic       vend_ok_nx, vend_deny_nx, coin_reject_nx;
  logic       refund_valid_nx, refund_auto_nx;
  logic       clear_timer;
  logic       timeout_hit;

  assign coin_edge = coin_btn & ~coin_q;
  assign coin_sum  = {1'b0, credit} + {1'b0, pend_value};

`ifdef COIN_AUTO_REFUND_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_timer;

  assign timeout_hit = (state == ST_CREDIT) && (idle_timer == CNT_LAST);

  // Idle timer: restarts on any credit activity or outside CREDIT, else counts
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_timer <= '0;
    end else if (clear_timer || state != ST_CREDIT || state_nx != ST_CREDIT) begin
      idle_timer <= '0;
    end else begin
      idle_timer <= idle_timer + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = clear_timer ^ (TIMEOUT_CYCLES > 0);
`endif

  // Arbitrate refund > vend > pending coin, then handle a new coin edge
  always_comb begin
    state_nx         = (state == ST_REFUND) ? ST_IDLE : state;
    credit_nx        = credit;
    pend_valid_nx    = pend_valid;
    pend_value_nx    = pend_value;
    refund_amount_nx = refund_amount;
    vend_ok_nx       = 1'b0;
    vend_deny_nx     = 1'b0;
    coin_reject_nx   = 1'b0;
    refund_valid_nx  = 1'b0;
    refund_auto_nx   = 1'b0;
    clear_timer      = 1'b0;

    if (state == ST_CREDIT && (refund_req || timeout_hit)) begin
      refund_valid_nx  = 1'b1;
      refund_amount_nx = credit;
      refund_auto_nx   = timeout_hit & ~refund_req;
      credit_nx        = 4'd0;
      state_nx         = ST_REFUND;
    end else if (vend_req) begin
      clear_timer = 1'b1;
      if (price <= credit) begin
        vend_ok_nx = 1'b1;
        credit_nx  = credit - price;
        if (price == credit) begin
          state_nx = ST_IDLE;
        end
      end else begin
        vend_deny_nx = 1'b1;
      end
    end else if (pend_valid) begin
      pend_valid_nx = 1'b0;
      if (coin_sum <= MAX_SUM) begin
        credit_nx   = coin_sum[3:0];
        state_nx    = ST_CREDIT;
        clear_timer = 1'b1;
      end else begin
        coin_reject_nx = 1'b1;
      end
    end

    if (coin_edge && coin_value != 4'd0) begin
      if (pend_valid) begin
        coin_reject_nx = 1'b1;
      end else begin
        pend_valid_nx = 1'b1;
        pend_value_nx = coin_value;
      end
    end
  end

  // State, credit, pending slot and registered result pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      coin_q        <= 1'b0;
      pend_valid    <= 1'b0;
      pend_value    <= 4'd0;
      credit        <= 4'd0;
      vend_ok       <= 1'b0;
      vend_deny     <= 1'b0;
      coin_reject   <= 1'b0;
      refund_valid  <= 1'b0;
      refund_amount <= 4'd0;
      refund_auto   <= 1'b0;
    end else begin
      state         <= state_nx;
      coin_q        <= coin_btn;
      pend_valid    <= pend_valid_nx;
      pend_value    <= pend_value_nx;
      credit        <= credit_nx;
      vend_ok       <= vend_ok_nx;
      vend_deny     <= vend_deny_nx;
      coin_reject   <= coin_reject_nx;
      refund_valid  <= refund_valid_nx;
      refund_amount <= refund_amount_nx;
      refund_auto   <= refund_auto_nx;
    end
  end

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// tb_coin_credit_accumulator
// Scoreboard bench: every stimulus cycle pushes the reference model's
// expected outputs, and a monitor compares them after each clock edge.
// Honours COIN_AUTO_REFUND_EN (timeout shortened to 20 cycles).
module tb_coin_credit_accumulator;

`ifdef COIN_AUTO_REFUND_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int TO = 20;

  typedef struct packed {
    logic [3:0] credit;
    logic       vok;
    logic       vdeny;
    logic       crej;
    logic       rvalid;
    logic [3:0] ramt;
    logic       rauto;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_btn = 1'b0;
  logic [3:0] coin_value = 4'd0;
  logic       vend_req = 1'b0;
  logic [3:0] price = 4'd0;
  logic       refund_req = 1'b0;
  logic [3:0] credit;
  logic       vend_ok, vend_deny, coin_reject, refund_valid, refund_auto;
  logic [3:0] refund_amount;

  int n_checks = 0;
  int n_fails  = 0;

  exp_t sb[$];

  // Reference model state: credit as a plain number, pending coins as a queue
  int m_credit = 0;
  int m_idle   = 0;
  int m_ramt   = 0;
  bit m_prev   = 1'b0;
  int m_pend[$];

  coin_credit_accumulator #(.MAX_CREDIT(15), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .coin_btn(coin_btn), .coin_value(coin_value),
    .vend_req(vend_req), .price(price), .refund_req(refund_req),
    .credit(credit), .vend_ok(vend_ok), .vend_deny(vend_deny),
    .coin_reject(coin_reject), .refund_valid(refund_valid),
    .refund_amount(refund_amount), .refund_auto(refund_auto)
  );

  always #5 clk = ~clk;

  // Outputs the DUT should show after the edge that consumes these inputs
  function automatic exp_t modelStep(bit rst, bit btn, int val, bit vreq, int pr, bit rreq);
    exp_t e;
    int   old;
    bit   had_pend;
    bit   active;
    bit   tmo;
    int   v;
    e = '0;
    if (rst) begin
      m_credit = 0; m_idle = 0; m_ramt = 0; m_prev = 1'b0;
      m_pend.delete();
      return e;
    end
    old      = m_credit;
    had_pend = (m_pend.size() > 0);
    active   = 1'b0;
    tmo      = AUTO && old > 0 && m_idle == TO - 1;
    if (old > 0 && (rreq || tmo)) begin
      e.rvalid = 1'b1;
      e.rauto  = tmo && !rreq;
      m_ramt   = old;
      m_credit = 0;
    end else if (vreq) begin
      active = 1'b1;
      if (pr <= old) begin
        e.vok    = 1'b1;
        m_credit = old - pr;
      end else begin
        e.vdeny = 1'b1;
      end
    end else if (had_pend) begin
      v = m_pend.pop_front();
      if (old + v <= 15) begin
        m_credit = old + v;
        active   = 1'b1;
      end else begin
        e.crej = 1'b1;
      end
    end
    if (btn && !m_prev && val != 0) begin
      if (had_pend) e.crej = 1'b1;
      else m_pend.push_back(val);
    end
    if (AUTO && old > 0 && m_credit > 0 && !active) m_idle = m_idle + 1;
    else m_idle = 0;
    m_prev   = btn;
    e.credit = 4'(m_credit);
    e.ramt   = 4'(m_ramt);
    return e;
  endfunction

  // Drive one cycle of inputs, record the model's expectation, wait a cycle
  task automatic applyStimulus(bit rst, bit btn, logic [3:0] val, bit vreq,
                               logic [3:0] pr, bit rreq);
    reset      = rst;
    coin_btn   = btn;
    coin_value = val;
    vend_req   = vreq;
    price      = pr;
    refund_req = rreq;
    sb.push_back(modelStep(rst, btn, int'(val), vreq, int'(pr), rreq));
    @(negedge clk);
  endtask

  // Compare the full output set against the scoreboard entry
  task automatic checkOutput(exp_t e);
    exp_t a;
    a = '{credit, vend_ok, vend_deny, coin_reject, refund_valid, refund_amount, refund_auto};
    n_checks++;
    if (a !== e) begin
      n_fails++;
      $display("[TB] FAIL outputs at %0t: got credit=%0d ok=%b deny=%b rej=%b rv=%b ramt=%0d auto=%b, expected credit=%0d ok=%b deny=%b rej=%b rv=%b ramt=%0d auto=%b",
               $time, a.credit, a.vok, a.vdeny, a.crej, a.rvalid, a.ramt, a.rauto,
               e.credit, e.vok, e.vdeny, e.crej, e.rvalid, e.ramt, e.rauto);
    end
  endtask

  // Directed check against a hand-derived constant
  task automatic checkDirect(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic coin(logic [3:0] v);
    applyStimulus(1'b0, 1'b1, v, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, v, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic vend(logic [3:0] p);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, p, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  // Monitor: pop one expectation per clock edge and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    bit btn_r;
    $display("[TB] start, auto-refund %0s", AUTO ? "on" : "off");
    doReset();
    doReset();
    checkDirect("reset_credit", int'(credit), 0);
    checkDirect("reset_pulses", int'({vend_ok, vend_deny, coin_reject, refund_valid, refund_auto}), 0);
    checkDirect("reset_ramt", int'(refund_amount), 0);

    coin(4'd5);
    checkDirect("coin5_credit", int'(credit), 5);
    coin(4'd4);
    checkDirect("coin4_credit", int'(credit), 9);
    vend(4'd7);
    checkDirect("vend7_ok", int'(vend_ok), 1);
    checkDirect("vend7_credit", int'(credit), 2);

    doReset();
    coin(4'd3);
    vend(4'd6);
    checkDirect("vend6_deny", int'(vend_deny), 1);
    checkDirect("vend6_credit", int'(credit), 3);
    vend(4'd3);
    checkDirect("vend3_ok", int'(vend_ok), 1);
    checkDirect("vend3_credit", int'(credit), 0);
    vend(4'd1);
    checkDirect("vend_idle_deny", int'(vend_deny), 1);
    vend(4'd0);
    checkDirect("vend_zero_ok", int'(vend_ok), 1);

    coin(4'd12);
    coin(4'd4);
    checkDirect("overflow_reject", int'(coin_reject), 1);
    checkDirect("overflow_credit", int'(credit), 12);
    coin(4'd3);
    checkDirect("fill_to_max", int'(credit), 15);

    doReset();
    coin(4'd6);
    applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b1);
    checkDirect("simul_rvalid", int'(refund_valid), 1);
    checkDirect("simul_ramt", int'(refund_amount), 6);
    checkDirect("simul_credit0", int'(credit), 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    checkDirect("simul_credit2", int'(credit), 2);
    checkDirect("ramt_held", int'(refund_amount), 6);

    doReset();
    coin(4'd4);
`ifdef COIN_AUTO_REFUND_EN
    idle(TO - 1);
    checkDirect("auto_not_yet", int'(refund_valid), 0);
    idle(1);
    checkDirect("auto_rvalid", int'(refund_valid), 1);
    checkDirect("auto_flag", int'(refund_auto), 1);
    checkDirect("auto_ramt", int'(refund_amount), 4);
`else
    idle(100);
    checkDirect("hold_credit", int'(credit), 4);
`endif

    doReset();
    coin(4'd9);
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
    doReset();
    checkDirect("midreset_credit", int'(credit), 0);
    checkDirect("midreset_pulses", int'({vend_ok, vend_deny, coin_reject, refund_valid}), 0);
    idle(3);
    checkDirect("midreset_no_coin", int'(credit), 0);

    btn_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) idle(TO + 5);
      if ($urandom_range(0, 2) == 0) btn_r = ~btn_r;
      applyStimulus($urandom_range(0, 299) == 0, btn_r, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 19) == 0);
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
